// File: rtl/mod_exp1_if.sv
// Request/response bundle for the mod_exp1 Montgomery exponentiator.
// With MOD_EXP1_BUSY_EN defined the bundle also carries the busy status.
interface mod_exp1_if #(
  parameter int unsigned LEN = 256
);
  logic           start;
  logic [LEN-1:0] a;
  logic [LEN-1:0] n;
  logic [LEN-1:0] n_prime;
  logic [LEN-1:0] r2_mod_n;
  logic [LEN-1:0] res;
  logic           done;
`ifdef MOD_EXP1_BUSY_EN
  logic           busy;

  modport master (output start, a, n, n_prime, r2_mod_n, input res, done, busy);
  modport slave  (input start, a, n, n_prime, r2_mod_n, output res, done, busy);
`else
  modport master (output start, a, n, n_prime, r2_mod_n, input res, done);
  modport slave  (input start, a, n, n_prime, r2_mod_n, output res, done);
`endif
endinterface : mod_exp1_if

// File: rtl/mod_exp1.sv
// mod_exp1: res = a^E mod n using one Montgomery product (REDC) per cycle
// under a left-to-right square-and-multiply sequencer.
// Optional feature macro: MOD_EXP1_BUSY_EN adds the busy output.
module mod_exp1 #(
  parameter int unsigned LEN = 256,
  parameter int unsigned E   = 65537
) (
  input  logic       clk,
  input  logic       rst_n,
  mod_exp1_if.slave  bus
);

  localparam int unsigned DW   = 2 * LEN;
  localparam int unsigned SW   = DW + 1;
  localparam int unsigned UW   = LEN + 1;
  localparam int unsigned IDXW = 5;

  // Index of the most significant set bit of the exponent.
  function automatic int unsigned msb_of(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 32'(i);
    end
    return r;
  endfunction

  localparam logic [31:0]     EXP      = 32'(E);
  localparam int unsigned     EMSB     = msb_of(E);
  localparam logic [IDXW-1:0] IDX_INIT = IDXW'(EMSB - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_TOMONT   = 2'd1;
  localparam logic [1:0] S_LOOP     = 2'd2;
  localparam logic [1:0] S_FROMMONT = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            mul_q, mul_d;
  logic [LEN-1:0]  a_q, a_d;
  logic [LEN-1:0]  n_q, n_d;
  logic [LEN-1:0]  np_q, np_d;
  logic [LEN-1:0]  r2_q, r2_d;
  logic [LEN-1:0]  am_q, am_d;
  logic [LEN-1:0]  x_q, x_d;
  logic [LEN-1:0]  res_q, res_d;
  logic            done_q, done_d;
`ifdef MOD_EXP1_BUSY_EN
  logic            busy_q, busy_d;
`endif

  logic [LEN-1:0]  mx, my;
  logic [DW-1:0]   t;
  logic [LEN-1:0]  m;
  logic [SW-1:0]   s;
  logic [UW-1:0]   u;
  logic [LEN-1:0]  mont_c;

  // Montgomery product of the operand pair selected by the current step.
  always_comb begin
    mx = x_q;
    my = x_q;
    case (state_q)
      S_TOMONT: begin
        mx = a_q;
        my = r2_q;
      end
      S_LOOP: begin
        if (mul_q) my = am_q;
      end
      S_FROMMONT: my = LEN'(1);
      default: ;
    endcase
    t      = DW'(mx) * DW'(my);
    m      = t[LEN-1:0] * np_q;
    s      = SW'(t) + SW'(m) * SW'(n_q);
    u      = s[SW-1:LEN];
    mont_c = (u >= UW'(n_q)) ? LEN'(u - UW'(n_q)) : LEN'(u);
  end

  // Sequencer next state and register updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mul_d   = mul_q;
    a_d     = a_q;
    n_d     = n_q;
    np_d    = np_q;
    r2_d    = r2_q;
    am_d    = am_q;
    x_d     = x_q;
    res_d   = res_q;
    done_d  = 1'b0;
`ifdef MOD_EXP1_BUSY_EN
    busy_d  = (state_q != S_IDLE);
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          n_d     = bus.n;
          np_d    = bus.n_prime;
          r2_d    = bus.r2_mod_n;
          state_d = S_TOMONT;
        end
      end
      S_TOMONT: begin
        am_d    = mont_c;
        x_d     = mont_c;
        idx_d   = IDX_INIT;
        mul_d   = 1'b0;
        state_d = (EMSB == 0) ? S_FROMMONT : S_LOOP;
      end
      S_LOOP: begin
        x_d = mont_c;
        if (!mul_q && EXP[idx_q]) begin
          mul_d = 1'b1;
        end else begin
          mul_d = 1'b0;
          if (idx_q == '0) state_d = S_FROMMONT;
          else             idx_d   = idx_q - IDXW'(1);
        end
      end
      S_FROMMONT: begin
        res_d   = mont_c;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mul_q   <= 1'b0;
      a_q     <= '0;
      n_q     <= '0;
      np_q    <= '0;
      r2_q    <= '0;
      am_q    <= '0;
      x_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mul_q   <= mul_d;
      a_q     <= a_d;
      n_q     <= n_d;
      np_q    <= np_d;
      r2_q    <= r2_d;
      am_q    <= am_d;
      x_q     <= x_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.res  = res_q;
  assign bus.done = done_q;

`ifdef MOD_EXP1_BUSY_EN
  // Busy flag covers every non-idle step through the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= busy_d;
  end

  assign bus.busy = busy_q;
`endif

endmodule : mod_exp1

// File: tb/tb_mod_exp1.sv
// Randomized scoreboard bench for mod_exp1 against a plain modular-arithmetic model.
module tb_mod_exp1;

  localparam int unsigned LEN = 256;
  localparam int unsigned E   = 65537;
  localparam int unsigned P   = 19;

  localparam logic [LEN-1:0] KN   = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
  localparam logic [LEN-1:0] KNP  = 256'hc9bd1905155383999c46c2c295f2b761bcb223fedc24a059d838091dd2253531;
  localparam logic [LEN-1:0] KR2  = 256'h1000007a2000e90a1;
  localparam logic [LEN-1:0] KA   = 256'ha1b2c3d4e5f67890123456789012345678901234567890123456789012345678;
  localparam logic [LEN-1:0] KRES = 256'h6529839e9bf0ce322932bdcc612f5f3866cf4c7abf15bff66b324e253bb35bc3;

  typedef struct {
    logic [LEN-1:0] res;
    int unsigned    due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned next_free;
  int          checks;
  int          errors;
  exp_t        q[$];

  mod_exp1_if #(.LEN(LEN)) bus ();

  mod_exp1 #(.LEN(LEN), .E(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: square-and-multiply with ordinary modular reduction.
  function automatic logic [LEN-1:0] ref_exp(input logic [LEN-1:0] a, input logic [LEN-1:0] n);
    logic [2*LEN-1:0] acc;
    logic [31:0]      ev;
    ev  = E;
    acc = (2*LEN)'(1) % (2*LEN)'(n);
    for (int i = 31; i >= 0; i--) begin
      acc = (acc * acc) % (2*LEN)'(n);
      if (ev[i]) acc = (acc * (2*LEN)'(a)) % (2*LEN)'(n);
    end
    return LEN'(acc);
  endfunction

  function automatic logic [LEN-1:0] rnd();
    logic [LEN-1:0] v;
    for (int i = 0; i < LEN / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [LEN-1:0] calc_np(input logic [LEN-1:0] n);
    logic [LEN-1:0] inv;
    inv = n;
    for (int i = 0; i < 8; i++) inv = inv * (LEN'(2) - n * inv);
    return LEN'(0) - inv;
  endfunction

  function automatic logic [LEN-1:0] calc_r2(input logic [LEN-1:0] n);
    logic [2*LEN:0] big;
    big         = '0;
    big[2*LEN]  = 1'b1;
    return LEN'(big % (2*LEN+1)'(n));
  endfunction

  // One clock of stimulus; records an expected result when the DUT is idle to accept it.
  task automatic step(input logic s, input logic [LEN-1:0] va, input logic [LEN-1:0] vn,
                      input logic [LEN-1:0] vnp, input logic [LEN-1:0] vr2);
    exp_t e;
    bus.start    = s;
    bus.a        = va;
    bus.n        = vn;
    bus.n_prime  = vnp;
    bus.r2_mod_n = vr2;
    @(posedge clk);
    if (s && rst_n && cyc >= next_free) begin
      e.res = ref_exp(va, vn);
      e.due = cyc + P + 1;
      q.push_back(e);
      next_free = cyc + P + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, rnd(), rnd(), rnd(), rnd());
  endtask

  // Start one operation, then scramble inputs and poke start mid-flight.
  task automatic run_op(input logic [LEN-1:0] va, input logic [LEN-1:0] vn,
                        input logic [LEN-1:0] vnp, input logic [LEN-1:0] vr2);
    step(1'b1, va, vn, vnp, vr2);
    for (int i = 1; i <= P; i++) begin
      step((i == 5 || i == 11) ? 1'b1 : 1'b0, rnd(), rnd(), rnd(), rnd());
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      idle_step();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  // Compares every done pulse against the head of the scoreboard.
  task automatic monitor();
    exp_t e;
`ifdef MOD_EXP1_BUSY_EN
    logic busy_exp;
`endif
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
`ifdef MOD_EXP1_BUSY_EN
        busy_exp = (q.size() > 0) && (cyc + P - 1 >= q[0].due);
        checks++;
        if (bus.busy !== busy_exp) begin
          errors++;
          $display("FAIL busy cyc=%0d got %b required %b", cyc, bus.busy, busy_exp);
        end
`endif
        if (bus.done === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d", cyc);
          end else begin
            e = q.pop_front();
            if (bus.res !== e.res) begin
              errors++;
              $display("FAIL res got %h required %h", bus.res, e.res);
            end
            checks++;
            if (cyc != e.due) begin
              errors++;
              $display("FAIL latency cyc got %0d required %0d", cyc, e.due);
            end
          end
        end else if (q.size() > 0 && cyc >= q[0].due) begin
          checks++;
          errors++;
          $display("FAIL missing_done cyc=%0d required at %0d", cyc, q[0].due);
          void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.res !== '0) begin
      errors++;
      $display("FAIL %s_res got %h required 0", tag, bus.res);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got %b required 0", tag, bus.done);
    end
`ifdef MOD_EXP1_BUSY_EN
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got %b required 0", tag, bus.busy);
    end
`endif
  endtask

  initial begin
    logic [LEN-1:0] rn, rnp, rr2;
    cyc          = 0;
    next_free    = 0;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.n        = '0;
    bus.n_prime  = '0;
    bus.r2_mod_n = '0;
    fork
      monitor();
    join_none

    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    idle_step();
    rst_n = 1'b1;
    idle_step();

    // Known vector and boundary bases on the reference modulus.
    run_op(KA, KN, KNP, KR2);
    drain();
    checks++;
    if (bus.res !== KRES) begin
      errors++;
      $display("FAIL known_vector got %h required %h", bus.res, KRES);
    end
    run_op('0, KN, KNP, KR2);
    run_op(LEN'(1), KN, KNP, KR2);
    run_op(KN - LEN'(1), KN, KNP, KR2);
    drain();

    // Random odd moduli with locally derived Montgomery constants.
    for (int k = 0; k < 4; k++) begin
      rn           = rnd();
      rn[LEN-1]    = 1'b1;
      rn[0]        = 1'b1;
      rnp          = calc_np(rn);
      rr2          = calc_r2(rn);
      run_op(rnd() % rn, rn, rnp, rr2);
      run_op(rnd() % rn, rn, rnp, rr2);
    end
    drain();

    // start held high: a new operation every P+1 cycles.
    rn = rnd() % KN;
    for (int i = 0; i < 3 * (P + 1); i++) step(1'b1, rn, KN, KNP, KR2);
    drain();

    // Reset in the middle of an operation aborts it with no done pulse.
    step(1'b1, KA, KN, KNP, KR2);
    for (int i = 0; i < 9; i++) idle_step();
    rst_n     = 1'b0;
    q.delete();
    next_free = 0;
    #1;
    check_reset_outputs("abort");
    idle_step();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) idle_step();
    run_op(KA, KN, KNP, KR2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mod_exp1
